// File: rtl/unified_block_memory_pkg.sv
/*
 * +----------------------------------------------------------------------+
 * | Module   : umem_pkg                                                  |
 * | Purpose  : FSM encoding and sizing helpers for unified_block_memory  |
 * | Revision : 1.0                                                       |
 * +----------------------------------------------------------------------+
 */
`default_nettype none

package umem_pkg;

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACCESS = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;

  // Width needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // Low bit of slice `port` in a flattened bus of `width`-bit slices.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/unified_block_memory_rr_arbiter.sv
/*
 * +----------------------------------------------------------------------+
 * | Module   : rr_arbiter                                                |
 * | Purpose  : Combinational round-robin pick starting at i_ptr          |
 * | Revision : 1.0                                                       |
 * +----------------------------------------------------------------------+
 */
`default_nettype none

module rr_arbiter
  import umem_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  // First pass covers ports at or above the pointer, second pass wraps.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j] && (j >= int'(i_ptr))) begin
        o_grant[j] = 1'b1;
        o_idx      = PW'(j);
        o_any      = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j] && (j < int'(i_ptr))) begin
        o_grant[j] = 1'b1;
        o_idx      = PW'(j);
        o_any      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/unified_block_memory.sv
/*
 * +----------------------------------------------------------------------+
 * | Module   : unified_block_memory                                      |
 * | Purpose  : Block memory shared by NUM_PORTS cache masters, RR grant  |
 * |            Optional: MEM_STATS_EN adds ACCESS_COUNT / STALL_COUNT    |
 * | Revision : 1.0                                                       |
 * +----------------------------------------------------------------------+
 */
`default_nettype none

module unified_block_memory
  import umem_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int BLOCK_WIDTH = 128,
  parameter int ADDR_WIDTH  = 28,
  parameter int DEPTH_LOG2  = 8,
  parameter int LATENCY     = 5
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [NUM_PORTS-1:0]             READ,
  input  logic [NUM_PORTS-1:0]             WRITE,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  ADDRESS,
  input  logic [NUM_PORTS*BLOCK_WIDTH-1:0] WRITEDATA,
  output logic [NUM_PORTS*BLOCK_WIDTH-1:0] READDATA,
  output logic [NUM_PORTS-1:0]             BUSYWAIT
`ifdef MEM_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]          ACCESS_COUNT,
  output logic [NUM_PORTS*32-1:0]          STALL_COUNT
`endif
);

  localparam int c_PW    = clog2(NUM_PORTS);
  localparam int c_CNT_W = clog2(LATENCY + 1);
  localparam int c_DEPTH = 1 << DEPTH_LOG2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [c_PW-1:0]        r_grant;
  logic [c_PW-1:0]        r_rr_ptr;
  logic                   r_op_write;
  logic [DEPTH_LOG2-1:0]  r_idx;
  logic [BLOCK_WIDTH-1:0] r_wdata;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [BLOCK_WIDTH-1:0] r_mem [c_DEPTH];

  logic [NUM_PORTS-1:0]   w_req;
  logic [NUM_PORTS-1:0]   w_grant_oh;
  logic [c_PW-1:0]        w_grant_idx;
  logic                   w_any_req;
  logic [DEPTH_LOG2-1:0]  w_req_idx;
  logic [BLOCK_WIDTH-1:0] w_req_wdata;
  logic                   w_req_write;
  logic                   w_commit;
  logic                   w_unused_addr;

  assign w_req         = READ | WRITE;
  assign w_commit      = (r_state == c_ST_ACCESS) && (r_cnt == '0);
  assign w_unused_addr = ^ADDRESS;

  rr_arbiter #(
    .N  (NUM_PORTS),
    .PW (c_PW)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant_oh),
    .o_idx   (w_grant_idx),
    .o_any   (w_any_req)
  );

  // AND-OR select of the winning port's request fields; WRITE wins over READ.
  always_comb begin
    w_req_idx   = '0;
    w_req_wdata = '0;
    w_req_write = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_grant_oh[p]) begin
        w_req_idx   = ADDRESS[slice_lo(p, ADDR_WIDTH) +: DEPTH_LOG2];
        w_req_wdata = WRITEDATA[slice_lo(p, BLOCK_WIDTH) +: BLOCK_WIDTH];
        w_req_write = WRITE[p];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_any_req) w_state_nxt = c_ST_ACCESS;
      c_ST_ACCESS: if (r_cnt == '0) w_state_nxt = c_ST_DONE;
      c_ST_DONE:   w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // The one low cycle of BUSYWAIT is the completion strobe for the master.
  always_comb begin
    BUSYWAIT = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      BUSYWAIT[p] = w_req[p] & ~((r_state == c_ST_DONE) && (r_grant == c_PW'(p)));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_op_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      READDATA   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_any_req) begin
            r_grant    <= w_grant_idx;
            r_op_write <= w_req_write;
            r_idx      <= w_req_idx;
            r_wdata    <= w_req_wdata;
            r_cnt      <= c_CNT_W'(LATENCY - 1);
          end
        end
        c_ST_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end else if (!r_op_write) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (r_grant == c_PW'(p))
                READDATA[slice_lo(p, BLOCK_WIDTH) +: BLOCK_WIDTH] <= r_mem[r_idx];
            end
          end
        end
        c_ST_DONE: begin
          r_rr_ptr <= (r_grant == c_PW'(NUM_PORTS - 1)) ? '0 : r_grant + c_PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Array has no reset so preloaded contents survive RESET.
  always_ff @(posedge CLK) begin
    if (!RESET && w_commit && r_op_write) r_mem[r_idx] <= r_wdata;
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ACCESS_COUNT <= '0;
      STALL_COUNT  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if ((r_state == c_ST_DONE) && (r_grant == c_PW'(p)))
          ACCESS_COUNT[p*32 +: 32] <= ACCESS_COUNT[p*32 +: 32] + 32'd1;
        if (BUSYWAIT[p])
          STALL_COUNT[p*32 +: 32] <= STALL_COUNT[p*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
